hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core (F/D/E/M/W). Tracks in-flight destination registers in its own shadow stage registers and produces the 2-bit operand-select codes that drive the execute-stage `mux3` forwarding muxes. It also raises fetch/decode stalls and decode/execute flushes for load-use hazards and taken branches. The core sees it as the single owner of every hazard decision.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_stage_reg.sv | 22 ++
 rtl/hazard_unit.sv | 133 +++++++++++++
 tb/tb_hazard_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller: operand-select
// encoding, shadow stage record and writer/match helpers.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Ordering matches the select inputs of the execute-stage mux3.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } stage_info_t;

  function automatic logic is_writer(input stage_info_t s);
    return s.we && (s.rd != REG_ZERO);
  endfunction

  function automatic logic rd_hits(input stage_info_t s,
                                   input logic [REG_AW-1:0] a,
                                   input logic [REG_AW-1:0] b);
    return is_writer(s) && ((s.rd == a) || (s.rd == b));
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage register: freezes on hold, loads an empty
// record on bubble, otherwise captures the upstream stage.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  stage_info_t d,
  output stage_info_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage RV32 core: forwarding selects,
// load-use stalls and branch flushes. Define HAZARD_FORWARDING_EN to enable
// E-stage forwarding; otherwise RAW hazards on E/M producers stall instead.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      d_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] d_rd_i,
  input  logic                      d_reg_write_i,
  input  logic                      d_is_load_i,
  input  logic                      branch_taken_i,
  input  logic                      mem_stall_i,
  output logic [1:0]                forward_a_o,
  output logic [1:0]                forward_b_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o
);

  stage_info_t d_info;
  stage_info_t e_q;
  stage_info_t m_q;
  stage_info_t w_q;
  fwd_sel_e    fwd_a;
  fwd_sel_e    fwd_b;
  logic        lu;
  logic        unused_fields;

  // An invalid D slot must never become a writer once it reaches E.
  always_comb begin
    d_info       = '0;
    d_info.valid = d_valid_i;
    d_info.rs1   = d_rs1_i;
    d_info.rs2   = d_rs2_i;
    d_info.rd    = d_rd_i;
    d_info.we    = d_valid_i & d_reg_write_i;
    d_info.ld    = d_valid_i & d_is_load_i;
  end

  hazard_stage_reg u_stage_e (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .hold   (mem_stall_i),
    .bubble (flush_e_o),
    .d      (d_info),
    .q      (e_q)
  );

  hazard_stage_reg u_stage_m (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .hold   (mem_stall_i),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  hazard_stage_reg u_stage_w (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .hold   (mem_stall_i),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

`ifdef HAZARD_FORWARDING_EN
  // M is the younger producer, so it wins when both M and W write the source.
  function automatic fwd_sel_e pick_fwd(input logic [REG_AW-1:0] src,
                                        input stage_info_t m,
                                        input stage_info_t w);
    if (is_writer(m) && (m.rd == src)) begin
      return FWD_MEM;
    end else if (is_writer(w) && (w.rd == src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (e_q.valid) begin
      fwd_a = pick_fwd(e_q.rs1, m_q, w_q);
      fwd_b = pick_fwd(e_q.rs2, m_q, w_q);
    end
    lu = d_valid_i && e_q.ld && rd_hits(e_q, d_rs1_i, d_rs2_i);
  end
`else
  // Without forwarding, any E or M producer blocks the D reader until it
  // reaches W, where the write-first register file covers it.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    lu    = d_valid_i && (rd_hits(e_q, d_rs1_i, d_rs2_i) ||
                          rd_hits(m_q, d_rs1_i, d_rs2_i));
  end
`endif

  // Priority: reset, memory freeze, branch redirect, load-use.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (!rst_n_i) begin
      stall_f_o = 1'b0;
    end else if (mem_stall_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (lu) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign forward_a_o = rst_n_i ? fwd_a : FWD_RF;
  assign forward_b_o = rst_n_i ? fwd_b : FWD_RF;

  assign unused_fields = ^{e_q, m_q, w_q};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; expectations follow
// whether HAZARD_FORWARDING_EN is defined for this build.
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       d_valid;
  logic [4:0] d_rs1;
  logic [4:0] d_rs2;
  logic [4:0] d_rd;
  logic       d_reg_write;
  logic       d_is_load;
  logic       branch_taken;
  logic       mem_stall;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  int testsRun = 0;
  int testsFailed = 0;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_unit #(.REG_ADDR_WIDTH(5)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .d_valid_i      (d_valid),
    .d_rs1_i        (d_rs1),
    .d_rs2_i        (d_rs2),
    .d_rd_i         (d_rd),
    .d_reg_write_i  (d_reg_write),
    .d_is_load_i    (d_is_load),
    .branch_taken_i (branch_taken),
    .mem_stall_i    (mem_stall),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .stall_f_o      (stall_f),
    .stall_d_o      (stall_d),
    .flush_d_o      (flush_d),
    .flush_e_o      (flush_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e}.
  function automatic logic [7:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic sf, input logic sd,
                                    input logic fd, input logic fe);
    return {fa, fb, sf, sd, fd, fe};
  endfunction

  localparam logic [7:0] ZERO  = 8'b00_00_0000;
  localparam logic [7:0] LUST  = 8'b00_00_1101;
  localparam logic [7:0] MSTL  = 8'b00_00_1100;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got fa/fb/sf/sd/fd/fe=%b expected %b",
               tag, observed, expected);
    end
  endtask

  task automatic expectOut(input string tag, input logic [7:0] expected);
    checkOutput(tag, {forward_a, forward_b, stall_f, stall_d, flush_d, flush_e},
                expected);
  endtask

  // Drives one D-stage slot mid-cycle and lets combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic we, input logic ld,
                               input logic br, input logic ms);
    @(negedge clk);
    d_valid      = v;
    d_rs1        = rs1;
    d_rs2        = rs2;
    d_rd         = rd;
    d_reg_write  = we;
    d_is_load    = ld;
    branch_taken = br;
    mem_stall    = ms;
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    expectOut("reset_outputs", ZERO);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    expectOut("reset_outputs_2", ZERO);
    rst_n = 1'b1;
    nop();
    expectOut("post_reset_empty", ZERO);
    drain();

    // add x5,x1,x2 ; sub x6,x5,x1
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("raw1_producer", ZERO);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("raw1_consumer_d", FWD ? ZERO : LUST);
    if (FWD) begin
      nop();
      expectOut("raw1_fwd_mem", pk(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("raw1_stall_2", LUST);
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("raw1_release", ZERO);
      nop();
      expectOut("raw1_no_fwd", ZERO);
    end
    drain();

    // add x5 ; add x7 ; sub x6,x5,x3
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("raw2_producer", ZERO);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("raw2_filler", ZERO);
    applyStimulus(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("raw2_consumer_d", FWD ? ZERO : LUST);
    if (FWD) begin
      nop();
      expectOut("raw2_fwd_wb", pk(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      applyStimulus(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("raw2_release", ZERO);
      nop();
      expectOut("raw2_no_fwd", ZERO);
    end
    drain();

    // add x5 ; add x5 ; sub x6,x5,x5 -> M beats W
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("mw_second_writer", ZERO);
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("mw_consumer_d", FWD ? ZERO : LUST);
    if (FWD) begin
      nop();
      expectOut("mw_fwd_prio", pk(2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      applyStimulus(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("mw_stall_2", LUST);
      applyStimulus(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("mw_release", ZERO);
    end
    drain();

    // lw x5,0(x1) ; add x6,x1,x5
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    expectOut("lu_load", ZERO);
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("lu_stall", LUST);
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("lu_next", FWD ? ZERO : LUST);
    if (!FWD) begin
      applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("lu_release", ZERO);
    end
    nop();
    expectOut("lu_fwd_wb", FWD ? pk(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0) : ZERO);
    drain();

    // Writers to x0 never create hazards.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("x0_no_stall", ZERO);
    nop();
    expectOut("x0_no_fwd", ZERO);
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("x0_load_no_stall", ZERO);
    drain();

    // Branch coincident with load-use squashes the consumer.
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    expectOut("br_over_lu", pk(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    nop();
    expectOut("br_bubble_in_e", ZERO);
    nop();
    expectOut("br_squash_no_fwd", ZERO);
    drain();

    // Memory freeze for 3 cycles with a RAW pending.
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    expectOut("ms_cycle1", MSTL);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    expectOut("ms_cycle2_branch", MSTL);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    expectOut("ms_cycle3", MSTL);
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("ms_release", FWD ? ZERO : LUST);
    if (FWD) begin
      nop();
      expectOut("ms_fwd_resume", pk(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("ms_stall_2", LUST);
      applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      expectOut("ms_resume", ZERO);
    end
    drain();

    // Reset during a load-use stall aborts it.
    applyStimulus(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("rst_pre_stall", LUST);
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("rst_mid_stall", ZERO);
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    expectOut("rst_empty_pipe", ZERO);
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
